// File: rtl/wb_stage_pkg.sv
// ---------------------------------------------------------------------------
// wb_stage_pkg
// Shared constants for the write-back stage and the load-extension helper.
//   LS_BYTE / LS_HALF / LS_WORD : load-size encodings carried down the pipe
//   REG_ZERO                    : hard-wired zero register, never written
//   LINK_OFFSET                 : JAL/JALR link value is PC + LINK_OFFSET
// ---------------------------------------------------------------------------
package wb_stage_pkg;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

    localparam int REG_ZERO    = 0;
    localparam int LINK_OFFSET = 8;

endpackage : wb_stage_pkg

// File: rtl/wb_load_ext.sv
// ---------------------------------------------------------------------------
// wb_load_ext
// Combinational lane select and sign/zero extension of a raw load word.
// Lanes are big-endian: byte offset 0 is the most significant byte.
// Ports:
//   load_size     in  2       LS_BYTE / LS_HALF / LS_WORD (other codes pass through)
//   load_unsigned in  1       zero-extend instead of sign-extend
//   byte_off      in  2       address[1:0] of the load; bit 0 ignored for halves
//   mem_data      in  DWIDTH  raw load word
//   load_data     out DWIDTH  extended result
// DWIDTH must be at least 32; lanes are taken from the top 32 bits.
// ---------------------------------------------------------------------------
module wb_load_ext
    import wb_stage_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [1:0]        load_size,
    input  logic              load_unsigned,
    input  logic [1:0]        byte_off,
    input  logic [DWIDTH-1:0] mem_data,
    output logic [DWIDTH-1:0] load_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        fill_b;
    logic        fill_h;

    always_comb begin
        lane_b = mem_data[DWIDTH-1 -: 8];
        case (byte_off)
            2'd0:    lane_b = mem_data[DWIDTH-1  -: 8];
            2'd1:    lane_b = mem_data[DWIDTH-9  -: 8];
            2'd2:    lane_b = mem_data[DWIDTH-17 -: 8];
            default: lane_b = mem_data[DWIDTH-25 -: 8];
        endcase
        // Half-word lanes only look at offset bit 1.
        lane_h = byte_off[1] ? mem_data[DWIDTH-17 -: 16] : mem_data[DWIDTH-1 -: 16];
    end

    assign fill_b = ~load_unsigned & lane_b[7];
    assign fill_h = ~load_unsigned & lane_h[15];

    always_comb begin
        load_data = mem_data;
        case (load_size)
            LS_BYTE: load_data = {{(DWIDTH-8){fill_b}}, lane_b};
            LS_HALF: load_data = {{(DWIDTH-16){fill_h}}, lane_h};
            default: load_data = mem_data;
        endcase
    end

endmodule : wb_load_ext

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
// Write-back end of the MIPS pipeline: MEM/WB pipeline register, result
// select, register-file write port, forwarding source and retire counter.
//
// Build option: define WB_LOAD_EXT_EN to capture load size / signedness /
// byte offset and extend sub-word loads through wb_load_ext. Without it the
// raw load word is written back unchanged and those three inputs are ignored.
//
// Ports:
//   wb_clk, wb_rst            clock (rising), async active-low reset
//   wb_valid_in .. wb_byte_off_in   MEM-stage instruction fields
//   wb_stall                  hold the MEM/WB register
//   wb_flush                  load a bubble (wins over stall)
//   wb_rf_wr_en/addr/data     register-file write port
//   wb_fwd_valid/addr/data    EX-stage bypass source
//   wb_retire_count           retired instruction count (wraps)
// ---------------------------------------------------------------------------
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5,
    parameter int CWIDTH = 32
) (
    input  logic              wb_clk,
    input  logic              wb_rst,
    input  logic              wb_valid_in,
    input  logic              wb_reg_write_in,
    input  logic              wb_mem_to_reg_in,
    input  logic              wb_link_in,
    input  logic [DWIDTH-1:0] wb_pc_in,
    input  logic [DWIDTH-1:0] wb_alu_result_in,
    input  logic [DWIDTH-1:0] wb_mem_data_in,
    input  logic [AWIDTH-1:0] wb_dest_in,
    input  logic [1:0]        wb_load_size_in,
    input  logic              wb_load_unsigned_in,
    input  logic [1:0]        wb_byte_off_in,
    input  logic              wb_stall,
    input  logic              wb_flush,
    output logic              wb_rf_wr_en,
    output logic [AWIDTH-1:0] wb_rf_addr,
    output logic [DWIDTH-1:0] wb_rf_data,
    output logic              wb_fwd_valid,
    output logic [AWIDTH-1:0] wb_fwd_addr,
    output logic [DWIDTH-1:0] wb_fwd_data,
    output logic [CWIDTH-1:0] wb_retire_count
);

    // MEM/WB register
    logic              mw_valid;
    logic              mw_reg_write;
    logic              mw_mem_to_reg;
    logic              mw_link;
    logic [DWIDTH-1:0] mw_pc;
    logic [DWIDTH-1:0] mw_alu;
    logic [DWIDTH-1:0] mw_mem_data;
    logic [AWIDTH-1:0] mw_dest;
`ifdef WB_LOAD_EXT_EN
    logic [1:0]        mw_load_size;
    logic              mw_load_unsigned;
    logic [1:0]        mw_byte_off;
`endif

    // Set once a held entry has already committed, so a stall does not
    // write the register file (or count the retire) a second time.
    logic              done;
    logic [CWIDTH-1:0] retire_count;

    logic [DWIDTH-1:0] load_data;
    logic [DWIDTH-1:0] result;
    logic              dest_live;

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            mw_valid         <= 1'b0;
            mw_reg_write     <= 1'b0;
            mw_mem_to_reg    <= 1'b0;
            mw_link          <= 1'b0;
            mw_pc            <= '0;
            mw_alu           <= '0;
            mw_mem_data      <= '0;
            mw_dest          <= '0;
`ifdef WB_LOAD_EXT_EN
            mw_load_size     <= '0;
            mw_load_unsigned <= 1'b0;
            mw_byte_off      <= '0;
`endif
            done             <= 1'b0;
            retire_count     <= '0;
        end else begin
            // The entry currently presented retires on this edge.
            if (mw_valid && !done)
                retire_count <= retire_count + CWIDTH'(1);

            if (wb_flush) begin
                mw_valid         <= 1'b0;
                mw_reg_write     <= 1'b0;
                mw_mem_to_reg    <= 1'b0;
                mw_link          <= 1'b0;
                mw_pc            <= '0;
                mw_alu           <= '0;
                mw_mem_data      <= '0;
                mw_dest          <= '0;
`ifdef WB_LOAD_EXT_EN
                mw_load_size     <= '0;
                mw_load_unsigned <= 1'b0;
                mw_byte_off      <= '0;
`endif
                done             <= 1'b0;
            end else if (wb_stall) begin
                done             <= mw_valid;
            end else begin
                mw_valid         <= wb_valid_in;
                mw_reg_write     <= wb_reg_write_in;
                mw_mem_to_reg    <= wb_mem_to_reg_in;
                mw_link          <= wb_link_in;
                mw_pc            <= wb_pc_in;
                mw_alu           <= wb_alu_result_in;
                mw_mem_data      <= wb_mem_data_in;
                mw_dest          <= wb_dest_in;
`ifdef WB_LOAD_EXT_EN
                mw_load_size     <= wb_load_size_in;
                mw_load_unsigned <= wb_load_unsigned_in;
                mw_byte_off      <= wb_byte_off_in;
`endif
                done             <= 1'b0;
            end
        end
    end

`ifdef WB_LOAD_EXT_EN
    wb_load_ext #(
        .DWIDTH(DWIDTH)
    ) u_load_ext (
        .load_size    (mw_load_size),
        .load_unsigned(mw_load_unsigned),
        .byte_off     (mw_byte_off),
        .mem_data     (mw_mem_data),
        .load_data    (load_data)
    );
`else
    assign load_data = mw_mem_data;

    // Extension controls have no effect in this build.
    logic unused_load_ext;
    assign unused_load_ext = ^{wb_load_size_in, wb_load_unsigned_in, wb_byte_off_in};
`endif

    // Link wins over mem_to_reg; PC + 8 wraps naturally at DWIDTH bits.
    always_comb begin
        result = mw_alu;
        if (mw_link)
            result = mw_pc + DWIDTH'(LINK_OFFSET);
        else if (mw_mem_to_reg)
            result = load_data;
    end

    assign dest_live = mw_valid && mw_reg_write && (mw_dest != AWIDTH'(REG_ZERO));

    assign wb_rf_wr_en     = dest_live && !done;
    assign wb_rf_addr      = mw_dest;
    assign wb_rf_data      = result;

    // Still the youngest value for its register while stalled.
    assign wb_fwd_valid    = dest_live;
    assign wb_fwd_addr     = mw_dest;
    assign wb_fwd_data     = result;

    assign wb_retire_count = retire_count;

endmodule : wb_stage

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage
// Self-checking bench for wb_stage: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_wb_stage;

`ifdef WB_LOAD_EXT_EN
    localparam bit EXT_EN = 1'b1;
`else
    localparam bit EXT_EN = 1'b0;
`endif

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b0;
    logic        valid_in = 0, reg_write_in = 0, mem_to_reg_in = 0, link_in = 0;
    logic [31:0] pc_in = 0, alu_in = 0, mem_in = 0;
    logic [4:0]  dest_in = 0;
    logic [1:0]  size_in = 0, off_in = 0;
    logic        uns_in = 0;
    logic        stall = 0, flush = 0;

    logic        rf_wr_en, fwd_valid;
    logic [4:0]  rf_addr, fwd_addr;
    logic [31:0] rf_data, fwd_data, retire_count;

    int n_cmp  = 0;
    int n_fail = 0;

    wb_stage dut (
        .wb_clk             (wb_clk),
        .wb_rst             (wb_rst),
        .wb_valid_in        (valid_in),
        .wb_reg_write_in    (reg_write_in),
        .wb_mem_to_reg_in   (mem_to_reg_in),
        .wb_link_in         (link_in),
        .wb_pc_in           (pc_in),
        .wb_alu_result_in   (alu_in),
        .wb_mem_data_in     (mem_in),
        .wb_dest_in         (dest_in),
        .wb_load_size_in    (size_in),
        .wb_load_unsigned_in(uns_in),
        .wb_byte_off_in     (off_in),
        .wb_stall           (stall),
        .wb_flush           (flush),
        .wb_rf_wr_en        (rf_wr_en),
        .wb_rf_addr         (rf_addr),
        .wb_rf_data         (rf_data),
        .wb_fwd_valid       (fwd_valid),
        .wb_fwd_addr        (fwd_addr),
        .wb_fwd_data        (fwd_data),
        .wb_retire_count    (retire_count)
    );

    always #5 wb_clk = ~wb_clk;

    // ---------------- reference model ----------------
    // One pending instruction in write-back, whether it has already
    // committed, and how many instructions have retired.
    typedef struct {
        bit          valid, rw, m2r, link;
        bit [31:0]   pc, alu, mem;
        bit [4:0]    dest;
        bit [1:0]    size, off;
        bit          uns;
    } instr_t;

    instr_t      m_ins;
    bit          m_committed;
    bit [31:0]   m_count;

    function automatic bit [31:0] ref_load(bit [31:0] m, bit [1:0] sz, bit u, bit [1:0] o);
        longint unsigned v;
        v = m;
        if (sz == 2'b00) begin
            v = (m >> (8 * (3 - int'(o)))) & 32'hFF;
            if (!u && v >= 128) v = v + 64'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (m >> (o[1] ? 0 : 16)) & 32'hFFFF;
            if (!u && v >= 32768) v = v + 64'hFFFF_0000;
        end
        return EXT_EN ? v[31:0] : m;
    endfunction

    function automatic bit [31:0] ref_result(instr_t i);
        if (i.link) return i.pc + 32'd8;
        if (i.m2r)  return ref_load(i.mem, i.size, i.uns, i.off);
        return i.alu;
    endfunction

    function automatic bit ref_fwd();
        return m_ins.valid && m_ins.rw && (m_ins.dest != 0);
    endfunction

    function automatic bit ref_wr();
        return ref_fwd() && !m_committed;
    endfunction

    task automatic model_clear();
        m_ins       = '{default: 0};
        m_committed = 0;
        m_count     = 0;
    endtask

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_edge();
        if (m_ins.valid && !m_committed) m_count = m_count + 1;
        if (flush) begin
            m_ins       = '{default: 0};
            m_committed = 0;
        end else if (stall) begin
            m_committed = m_ins.valid;
        end else begin
            m_ins.valid = valid_in; m_ins.rw = reg_write_in;
            m_ins.m2r = mem_to_reg_in; m_ins.link = link_in;
            m_ins.pc = pc_in; m_ins.alu = alu_in; m_ins.mem = mem_in;
            m_ins.dest = dest_in; m_ins.size = size_in;
            m_ins.uns = uns_in; m_ins.off = off_in;
            m_committed = 0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic drive(bit v, bit rw, bit m2r, bit lk, bit [31:0] pc, bit [31:0] alu,
                         bit [31:0] mem, bit [4:0] dest, bit [1:0] sz, bit u, bit [1:0] o);
        valid_in = v; reg_write_in = rw; mem_to_reg_in = m2r; link_in = lk;
        pc_in = pc; alu_in = alu; mem_in = mem; dest_in = dest;
        size_in = sz; uns_in = u; off_in = o;
        stall = 0; flush = 0;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        model_clear();
        wb_rst = 0;
        #3;
        n_cmp++;
        if ({rf_wr_en, rf_addr, rf_data, fwd_valid, fwd_addr, fwd_data, retire_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: wr=%b addr=%0d data=%h fwd=%b faddr=%0d fdata=%h cnt=%0d, want all 0",
                     rf_wr_en, rf_addr, rf_data, fwd_valid, fwd_addr, fwd_data, retire_count);
        end
        @(negedge wb_clk);
        wb_rst = 1;
        @(posedge wb_clk);
        #1;
    endtask

    task automatic test_alu_write();
        bit [31:0] c0;
        c0 = m_count;
        drive(1, 1, 0, 0, 32'h100, 32'h1234, 32'hDEAD, 5, 2, 0, 0);
        tick();
        idle();
        n_cmp++;
        if (rf_wr_en !== 1 || rf_addr !== 5 || rf_data !== 32'h1234 || fwd_valid !== 1) begin
            n_fail++;
            $display("FAIL alu_write: wr=%b addr=%0d data=%h fwd=%b, want 1/5/00001234/1",
                     rf_wr_en, rf_addr, rf_data, fwd_valid);
        end
        n_cmp++;
        if (fwd_addr !== 5 || fwd_data !== 32'h1234) begin
            n_fail++;
            $display("FAIL alu_fwd_value: addr=%0d data=%h, want 5/00001234", fwd_addr, fwd_data);
        end
        tick();
        n_cmp++;
        if (retire_count !== c0 + 1) begin
            n_fail++;
            $display("FAIL alu_count: got %0d want %0d", retire_count, c0 + 1);
        end
    endtask

    task automatic test_dest_zero();
        bit [31:0] c0;
        c0 = m_count;
        drive(1, 1, 0, 0, 0, 32'h55, 0, 0, 2, 0, 0);
        tick();
        idle();
        n_cmp++;
        if (rf_wr_en !== 0 || fwd_valid !== 0) begin
            n_fail++;
            $display("FAIL dest_zero: wr=%b fwd=%b, want 0/0", rf_wr_en, fwd_valid);
        end
        tick();
        n_cmp++;
        if (retire_count !== c0 + 1) begin
            n_fail++;
            $display("FAIL dest_zero_count: got %0d want %0d", retire_count, c0 + 1);
        end
    endtask

    task automatic test_stall_hold();
        bit [31:0] c0;
        c0 = m_count;
        drive(1, 1, 0, 0, 0, 32'hA, 0, 7, 2, 0, 0);
        tick();
        // Inputs change during the stall; the held entry must not move.
        drive(1, 1, 0, 0, 0, 32'hBAD, 0, 9, 2, 0, 0);
        stall = 1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rf_wr_en !== (i == 0) || fwd_valid !== 1 || rf_addr !== 7 || rf_data !== 32'hA) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: wr=%b fwd=%b addr=%0d data=%h, want %b/1/7/0000000a",
                         i, rf_wr_en, fwd_valid, rf_addr, rf_data, i == 0);
            end
            if (i < 3) tick();
        end
        idle();
        tick();
        n_cmp++;
        if (retire_count !== c0 + 1) begin
            n_fail++;
            $display("FAIL stall_count: got %0d want %0d", retire_count, c0 + 1);
        end
    endtask

    task automatic test_flush_stall();
        bit [31:0] c0;
        drive(1, 1, 0, 0, 0, 32'h33, 0, 3, 2, 0, 0);
        tick();
        stall = 1;
        tick();
        c0 = m_count;
        stall = 1; flush = 1;
        tick();
        idle();
        n_cmp++;
        if (rf_wr_en !== 0 || fwd_valid !== 0 || retire_count !== c0) begin
            n_fail++;
            $display("FAIL flush_stall: wr=%b fwd=%b cnt=%0d, want 0/0/%0d",
                     rf_wr_en, fwd_valid, retire_count, c0);
        end
        tick();
        n_cmp++;
        if (retire_count !== c0) begin
            n_fail++;
            $display("FAIL flush_count: got %0d want %0d", retire_count, c0);
        end
    endtask

    task automatic test_link_priority();
        drive(1, 1, 1, 1, 32'hFFFF_FFFC, 32'h1111, 32'h2222, 31, 2, 0, 0);
        tick();
        idle();
        n_cmp++;
        if (rf_data !== 32'h0000_0004 || rf_wr_en !== 1 || rf_addr !== 31) begin
            n_fail++;
            $display("FAIL link_wrap: data=%h wr=%b addr=%0d, want 00000004/1/31", rf_data, rf_wr_en, rf_addr);
        end
        tick();
    endtask

    task automatic test_load_ext();
        bit [31:0] want [3];
        bit [1:0]  sz   [3];
        bit        u    [3];
        bit [1:0]  o    [3];
        sz = '{2'b00, 2'b00, 2'b01};
        u  = '{1'b0, 1'b1, 1'b0};
        o  = '{2'd0, 2'd1, 2'd2};
        if (EXT_EN) want = '{32'hFFFF_FF80, 32'h0000_00FF, 32'h0000_7F01};
        else        want = '{32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01};
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 0, 0, 32'h1, 32'h80FF_7F01, 4, sz[i], u[i], o[i]);
            tick();
            n_cmp++;
            if (rf_data !== want[i] || fwd_data !== want[i]) begin
                n_fail++;
                $display("FAIL load_ext[%0d]: rf=%h fwd=%h want %h", i, rf_data, fwd_data, want[i]);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid_stall();
        drive(1, 1, 0, 0, 0, 32'h99, 0, 9, 2, 0, 0);
        tick();
        stall = 1;
        tick();
        #2;
        wb_rst = 0;
        model_clear();
        #1;
        n_cmp++;
        if (rf_wr_en !== 0 || fwd_valid !== 0 || rf_data !== 0 || retire_count !== 0) begin
            n_fail++;
            $display("FAIL reset_async: wr=%b fwd=%b data=%h cnt=%0d, want 0/0/0/0",
                     rf_wr_en, fwd_valid, rf_data, retire_count);
        end
        @(negedge wb_clk);
        wb_rst = 1;
        @(posedge wb_clk);
        #1;
        tick();
        n_cmp++;
        if (rf_wr_en !== 0 || fwd_valid !== 0 || retire_count !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_stall: wr=%b fwd=%b cnt=%0d, want 0/0/0", rf_wr_en, fwd_valid, retire_count);
        end
        idle();
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(1), $urandom_range(4) == 0,
                  $urandom, $urandom, $urandom, 5'($urandom_range(31)), 2'($urandom_range(2)),
                  $urandom_range(1), 2'($urandom_range(3)));
            stall = ($urandom_range(3) == 0);
            flush = ($urandom_range(9) == 0);
            tick();
            n_cmp++;
            if (rf_wr_en !== ref_wr() || fwd_valid !== ref_fwd() || rf_addr !== m_ins.dest ||
                rf_data !== ref_result(m_ins) || fwd_addr !== m_ins.dest ||
                fwd_data !== ref_result(m_ins) || retire_count !== m_count) begin
                n_fail++;
                $display("FAIL random[%0d]: wr=%b fwd=%b addr=%0d data=%h cnt=%0d, want %b/%b/%0d/%h/%0d",
                         n, rf_wr_en, fwd_valid, rf_addr, rf_data, retire_count,
                         ref_wr(), ref_fwd(), m_ins.dest, ref_result(m_ins), m_count);
            end
        end
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_dest_zero();
        test_stall_hold();
        test_flush_stall();
        test_link_priority();
        test_load_ext();
        test_random();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_wb_stage

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back end of the MIPS pipeline: MEM/WB pipeline register plus result select.
- Drives the register file's single write port (write enable, address, data).
- Publishes the same result as a forwarding source for the EX-stage bypass muxes.
- Keeps a retired-instruction counter.

Parameters:
DWIDTH, 32, data/result width
AWIDTH, 5, register address width (32 architectural registers)
CWIDTH, 32, retire counter width

Ports:
wb_clk  input  1  clock, rising edge
wb_rst  input  1  reset, asynchronous, active-low
wb_valid_in  input  1  MEM stage holds a real instruction
wb_reg_write_in  input  1  instruction writes a register
wb_mem_to_reg_in  input  1  result comes from load data
wb_link_in  input  1  JAL/JALR: result is PC+8
wb_pc_in  input  DWIDTH  PC of the instruction
wb_alu_result_in  input  DWIDTH  ALU result
wb_mem_data_in  input  DWIDTH  raw load word
wb_dest_in  input  AWIDTH  destination register
wb_load_size_in  input  2  00 byte, 01 half, 10 word (optional feature only)
wb_load_unsigned_in  input  1  zero-extend the load (optional feature only)
wb_byte_off_in  input  2  alu_result[1:0] of the load (optional feature only)
wb_stall  input  1  hold the MEM/WB register
wb_flush  input  1  load a bubble
wb_rf_wr_en  output  1  register-file write enable
wb_rf_addr  output  AWIDTH  register-file write address
wb_rf_data  output  DWIDTH  register-file write data
wb_fwd_valid  output  1  forwarding source valid
wb_fwd_addr  output  AWIDTH  forwarded register
wb_fwd_data  output  DWIDTH  forwarded value
wb_retire_count  output  CWIDTH  retired instructions

Behaviour:
- Reset (wb_rst=0, asynchronous): MEM/WB register cleared (valid=0, all fields 0), done flag cleared, retire count 0.
  - All outputs 0 while reset is asserted and until the first load.
- Capture at posedge wb_clk, priority order:
  - wb_flush: load bubble (valid=0); done=0.
  - else wb_stall: hold all fields; done=1 if held entry is valid.
  - else load all *_in fields; done=0.
- Outputs are combinational from the register.
  - The register file commits on the following edge, so the result is committed 2 edges after MEM presents it.
- Result select: link ? pc+8 (modulo 2^DWIDTH) : mem_to_reg ? load data : alu_result. Link wins over mem_to_reg.
- wb_rf_wr_en = valid & reg_write & (dest != 0) & !done.
  - A stalled entry writes exactly once.
  - Register 0 is never written.
- wb_rf_addr = dest; wb_rf_data = selected result. Both are driven even when the enable is low.
- wb_fwd_valid = valid & reg_write & (dest != 0). It stays high while stalled, because the value is still the youngest.
  - wb_fwd_addr and wb_fwd_data equal the rf address and data.
- Retire counter: +1 on each posedge where valid & !done, regardless of reg_write. Wraps from 2^CWIDTH-1 to 0.
- Flush and stall asserted together: flush wins, bubble loaded.
- Reset mid-stall: entry dropped, counter zeroed, no write issued.

Optional Feature:
- Macro WB_LOAD_EXT_EN.
- Defined: load data = lane selected by wb_byte_off_in from wb_mem_data_in, big-endian lanes.
  - Byte: offset 0 = bits 31:24 … offset 3 = bits 7:0.
  - Half: offset 0 = bits 31:16, offset 2 = bits 15:0; offset bit 0 is ignored.
  - Word: pass-through.
  - Sign-extended unless wb_load_unsigned_in, then zero-extended.
  - The three fields are captured in the MEM/WB register.
- Undefined: load data = wb_mem_data_in unchanged. The three ports remain but are ignored and not registered.

Decomposition:
- Shared package/header holds:
  - Load-size encodings (LS_BYTE=2'b00, LS_HALF=2'b01, LS_WORD=2'b10).
  - REG_ZERO address constant.
  - Link offset constant 8.
- Natural sub-module: wb_load_ext, combinational lane select and extension.
  - Instantiated only under WB_LOAD_EXT_EN; shared later with the data-cache path.

Test Plan:
- ALU write: valid, reg_write, dest=5, alu=0x1234 -> next cycle wr_en=1, addr=5, data=0x1234, fwd_valid=1; count 0->1.
- Dest zero: dest=0, reg_write=1 -> wr_en=0, fwd_valid=0; count still increments.
- Stall hold: load dest=7, alu=0xA, then stall 3 cycles -> wr_en high first cycle only, fwd_valid high all 4 cycles; count +1 total.
- Flush+stall same edge while dest=3 held -> next cycle valid=0, wr_en=0, fwd_valid=0; count unchanged.
- Link priority: link=1, mem_to_reg=1, pc=0xFFFFFFFC -> data=0x00000004 (wrap).
- WB_LOAD_EXT_EN: mem_data=0x80FF7F01, byte, off=0 signed -> 0xFFFFFF80; off=1 unsigned -> 0x000000FF; half, off=2 signed -> 0x00007F01. Without the macro -> 0x80FF7F01.
